// File: rtl/nano_cpu_p_if.sv
// Memory bus between nano_cpu_p and a single-port synchronous memory.
// The CPU is the master. It drives the address, write data and strobes,
// and the memory answers with read data and a ready flag.
interface nano_cpu_p_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] dataR;
    logic [DATA_W-1:0] dataW;
    logic              ce;
    logic              we;
    logic              rdy;

    modport master (
        output address, dataW, ce, we,
        input  dataR, rdy
    );

    modport slave (
        input  address, dataW, ce, we,
        output dataR, rdy
    );
endinterface

// File: rtl/nano_cpu_p.sv
// Parametrised 4-register nano CPU.
// Each instruction runs through FETCH -> EXEC -> execute state. The memory
// states FETCH, LD and WRITE wait for rdy. HALT is absorbing until reset.
module nano_cpu_p #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter bit SIGNED_LESS = 1'b0
) (
    input  logic         ck,
    input  logic         rst,
    nano_cpu_p_if.master bus,
    output logic         halted
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_LD,
        S_WRITE,
        S_ALU,
        S_JMP,
        S_BRANCH,
        S_HALT
    } state_e;

    localparam logic [3:0] OP_READ   = 4'h0;
    localparam logic [3:0] OP_WRITE  = 4'h1;
    localparam logic [3:0] OP_JMP    = 4'h2;
    localparam logic [3:0] OP_BRANCH = 4'h3;
    localparam logic [3:0] OP_XOR    = 4'h4;
    localparam logic [3:0] OP_SUB    = 4'h5;
    localparam logic [3:0] OP_ADD    = 4'h6;
    localparam logic [3:0] OP_LESS   = 4'h7;

    state_e state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] r_q [4];

    // Register-file write port, driven by the FSM.
    logic              reg_we;
    logic [1:0]        reg_wa;
    logic [DATA_W-1:0] reg_wd;

    // Instruction fields.
    logic [3:0]        f_op;
    logic [1:0]        f_rd, f_rs1, f_rs2;
    logic [ADDR_W-1:0] f_addr;

    assign f_op   = ir_q[15:12];
    assign f_rd   = ir_q[9:8];
    assign f_rs1  = ir_q[5:4];
    assign f_rs2  = ir_q[1:0];
    assign f_addr = ir_q[ADDR_W+3:4];

    logic [DATA_W-1:0] rs1_val, rs2_val;
    assign rs1_val = r_q[f_rs1];
    assign rs2_val = r_q[f_rs2];

    // PC arithmetic happens in the low ADDR_W bits only, so the upper bits stay 0.
    logic [ADDR_W-1:0] pc_lo_inc;
    logic [DATA_W-1:0] pc_inc;
    logic [DATA_W-1:0] addr_ext;
    assign pc_lo_inc = pc_q[ADDR_W-1:0] + ADDR_W'(1);
    assign pc_inc    = DATA_W'(pc_lo_inc);
    assign addr_ext  = DATA_W'(f_addr);

    // Only some IR bits and the low PC bits feed logic. These reductions keep the rest visibly consumed.
    logic ir_unused, pc_unused;
    assign ir_unused = ^ir_q;
    assign pc_unused = ^pc_q;

    logic less_flag;
    assign less_flag = SIGNED_LESS ? ($signed(rs1_val) < $signed(rs2_val))
                                   : (rs1_val < rs2_val);

    logic [DATA_W-1:0] alu_res;

    // ALU result for the register-to-register opcodes.
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        alu_res = '0;
        case (f_op)
            OP_XOR:  alu_res = rs1_val ^ rs2_val;
            OP_SUB:  alu_res = rs1_val - rs2_val;
            OP_ADD:  alu_res = rs1_val + rs2_val;
            OP_LESS: alu_res = DATA_W'(less_flag);
            default: alu_res = '0;
        endcase
    end

    // Next-state, PC/IR/register updates and memory bus outputs.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        reg_we      = 1'b0;
        reg_wa      = f_rd;
        reg_wd      = alu_res;
        bus.ce      = 1'b0;
        bus.we      = 1'b0;
        bus.address = f_addr;
        bus.dataW   = rs2_val;
        halted      = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                bus.ce      = 1'b1;
                bus.address = pc_q[ADDR_W-1:0];
                if (bus.rdy) begin
                    ir_d    = bus.dataR;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                case (f_op)
                    OP_READ:   state_d = S_LD;
                    OP_WRITE:  state_d = S_WRITE;
                    OP_JMP:    state_d = S_JMP;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_XOR, OP_SUB, OP_ADD, OP_LESS: state_d = S_ALU;
                    default:   state_d = S_HALT;
                endcase
            end

            S_LD: begin
                bus.ce = 1'b1;
                if (bus.rdy) begin
                    reg_we  = 1'b1;
                    reg_wa  = f_rs2;
                    reg_wd  = bus.dataR;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end

            S_WRITE: begin
                bus.ce = 1'b1;
                bus.we = 1'b1;
                if (bus.rdy) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end

            S_ALU: begin
                reg_we  = 1'b1;
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end

            S_JMP: begin
                pc_d    = addr_ext;
                state_d = S_FETCH;
            end

            S_BRANCH: begin
                pc_d    = (rs2_val != '0) ? addr_ext : pc_inc;
                state_d = S_FETCH;
            end

            S_HALT: halted = 1'b1;

            default: state_d = S_IDLE;
        endcase
    end

    // State, PC, IR and register file. All of them clear asynchronously on rst.
    // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            // NOTE: the four-entry register file is architectural state and is cleared on reset like the other flops.
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            if (reg_we) begin
                r_q[reg_wa] <= reg_wd;
            end
        end
    end

endmodule

// File: tb/tb_nano_cpu_p.sv
// Directed bench for nano_cpu_p. Two instances differ only in SIGNED_LESS
// and share the clock, reset, ready and program image. Each has its own memory.
module tb_nano_cpu_p;

    localparam int DW = 16;
    localparam int AW = 8;

    logic ck;
    logic rst;
    logic rdy;
    logic halted_u, halted_s;

    logic [DW-1:0] img   [256];
    logic [DW-1:0] mem_u [256];
    logic [DW-1:0] mem_s [256];

    int n_total = 0;
    int n_bad   = 0;

    nano_cpu_p_if #(.DATA_W(DW), .ADDR_W(AW)) bus_u ();
    nano_cpu_p_if #(.DATA_W(DW), .ADDR_W(AW)) bus_s ();

    nano_cpu_p #(.DATA_W(DW), .ADDR_W(AW), .SIGNED_LESS(1'b0)) dut (
        .ck(ck), .rst(rst), .bus(bus_u), .halted(halted_u)
    );
    nano_cpu_p #(.DATA_W(DW), .ADDR_W(AW), .SIGNED_LESS(1'b1)) dut_s (
        .ck(ck), .rst(rst), .bus(bus_s), .halted(halted_s)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    assign bus_u.rdy   = rdy;
    assign bus_s.rdy   = rdy;
    assign bus_u.dataR = mem_u[bus_u.address];
    assign bus_s.dataR = mem_s[bus_s.address];

    // Memories reload from the image while reset is held and otherwise accept writes.
    always @(posedge ck) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                mem_u[i] <= img[i];
                mem_s[i] <= img[i];
            end
        end else begin
            if (bus_u.ce && bus_u.we && rdy) mem_u[bus_u.address] <= bus_u.dataW;
            if (bus_s.ce && bus_s.we && rdy) mem_s[bus_s.address] <= bus_s.dataW;
        end
    end

    // Write-cycle monitor on the unsigned instance.
    int            wr_cnt = 0;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    always @(negedge ck) begin
        if (bus_u.ce && bus_u.we) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= bus_u.address;
            wr_data <= bus_u.dataW;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = '0;
    endtask

    // Hold reset across two edges so the memories load, then release on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge ck);
        @(negedge ck);
        rst = 1'b0;
    endtask

    task automatic run_halt(input string tag);
        int n;
        n = 0;
        while (!(halted_u && halted_s) && n < 300) begin
            @(negedge ck);
            n++;
        end
        check(tag, {30'd0, halted_u, halted_s}, 32'h3);
    endtask

    int n;
    int wr_base;

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        clear_img();

        // ---- reset state ----
        repeat (2) @(posedge ck);
        @(negedge ck);
        check("rst_ce", bus_u.ce, 0);
        check("rst_we", bus_u.we, 0);
        check("rst_halted", halted_u, 0);
        check("rst_address", bus_u.address, 0);
        check("rst_dataW", bus_u.dataW, 0);
        check("rst_pc", dut.pc_q, 0);

        // ---- READ, READ, ADD, END with rdy tied high ----
        img[0] = 16'h0101; img[1] = 16'h0112; img[2] = 16'h6012; img[3] = 16'h8000;
        img[16'h10] = 16'd5; img[16'h11] = 16'd3;
        do_reset();
        @(negedge ck);
        check("first_fetch_ce", bus_u.ce, 1);
        check("first_fetch_addr", bus_u.address, 0);
        n = 0;
        while (!halted_u && n < 50) begin
            @(negedge ck);
            n++;
        end
        check("add_latency", n, 11);
        check("add_halted", halted_u, 1);
        check("add_r0", dut.r_q[0], 16'h0008);
        check("add_r1", dut.r_q[1], 16'h0005);
        check("halt_ce", bus_u.ce, 0);

        // Asynchronous reset from HALT clears everything without a clock edge.
        #2 rst = 1'b1;
        #1;
        check("areset_halted", halted_u, 0);
        check("areset_r0", dut.r_q[0], 0);
        check("areset_ir", dut.ir_q, 0);

        // ---- SUB, XOR, same register as source and destination ----
        clear_img();
        img[0] = 16'h0101; img[1] = 16'h0112; img[2] = 16'h5012;
        img[3] = 16'h4312; img[4] = 16'h6121; img[5] = 16'h8000;
        img[16'h10] = 16'd3; img[16'h11] = 16'd5;
        do_reset();
        run_halt("sub_halt");
        check("sub_r0", dut.r_q[0], 16'hFFFE);
        check("xor_r3", dut.r_q[3], 16'h0006);
        check("add_old_r1", dut.r_q[1], 16'h0008);
        check("sub_pc", dut.pc_q, 16'h0005);

        // ---- LESS unsigned versus signed ----
        clear_img();
        img[0] = 16'h0101; img[1] = 16'h0112; img[2] = 16'h7012;
        img[3] = 16'h7321; img[4] = 16'h8000;
        img[16'h10] = 16'hFFFF; img[16'h11] = 16'h0001;
        do_reset();
        run_halt("less_halt");
        check("lessu_ffff_lt_1", dut.r_q[0], 0);
        check("lessu_1_lt_ffff", dut.r_q[3], 1);
        check("lesss_m1_lt_1", dut_s.r_q[0], 1);
        check("lesss_1_lt_m1", dut_s.r_q[3], 0);

        // ---- WRITE then read back ----
        clear_img();
        img[0] = 16'h0303; img[1] = 16'h1203; img[2] = 16'h0200; img[3] = 16'h8000;
        img[16'h30] = 16'hABCD;
        do_reset();
        wr_base = wr_cnt;
        run_halt("write_halt");
        check("write_cycles", wr_cnt - wr_base, 1);
        check("write_addr", wr_addr, 16'h20);
        check("write_data", wr_data, 16'hABCD);
        check("write_mem", mem_u[8'h20], 16'hABCD);
        check("write_readback", dut.r_q[0], 16'hABCD);

        // ---- rdy held low four cycles in FETCH and in LD ----
        clear_img();
        img[0] = 16'h0101; img[1] = 16'h8000;
        img[16'h10] = 16'h0055;
        rdy = 1'b0;
        do_reset();
        @(negedge ck);
        n = 0;
        check("wait_fetch_ce", bus_u.ce, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge ck);
            n++;
            check("wait_fetch_addr", bus_u.address, 0);
            check("wait_fetch_ir", dut.ir_q, 0);
        end
        rdy = 1'b1;
        @(negedge ck);
        n++;
        rdy = 1'b0;
        check("wait_exec_ce", bus_u.ce, 0);
        check("wait_exec_ir", dut.ir_q, 16'h0101);
        @(negedge ck);
        n++;
        check("wait_ld_ce", bus_u.ce, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge ck);
            n++;
            check("wait_ld_addr", bus_u.address, 16'h10);
            check("wait_ld_r1", dut.r_q[1], 0);
        end
        rdy = 1'b1;
        @(negedge ck);
        n++;
        check("wait_ld_done_r1", dut.r_q[1], 16'h0055);
        check("wait_ld_done_pc", dut.pc_q, 1);
        check("wait_next_fetch", bus_u.address, 1);
        check("wait_latency", n, 11);
        run_halt("wait_halt");

        // ---- BRANCH not taken, taken, and JMP ----
        clear_img();
        img[0] = 16'h0101; img[1] = 16'h3071; img[2] = 16'h8000; img[7] = 16'h8000;
        img[16'h10] = 16'h0000;
        do_reset();
        run_halt("bra_nt_halt");
        check("bra_not_taken_pc", dut.pc_q, 16'h0002);
        img[16'h10] = 16'h0007;
        do_reset();
        run_halt("bra_t_halt");
        check("bra_taken_pc", dut.pc_q, 16'h0007);
        clear_img();
        img[0] = 16'h20F0; img[16'h0F] = 16'h8000;
        do_reset();
        run_halt("jmp_halt");
        check("jmp_pc", dut.pc_q, 16'h000F);

        // ---- reset in the middle of a stalled LD ----
        clear_img();
        img[0] = 16'h0112; img[1] = 16'h0101; img[2] = 16'h8000;
        img[16'h10] = 16'h0009; img[16'h11] = 16'h0004;
        rdy = 1'b1;
        do_reset();
        n = 0;
        while (!(bus_u.ce && !bus_u.we && bus_u.address == 8'h10) && n < 20) begin
            @(negedge ck);
            n++;
        end
        rdy = 1'b0;
        check("abort_reach_ld", bus_u.address, 16'h10);
        repeat (2) @(negedge ck);
        check("abort_pre_pc", dut.pc_q, 1);
        check("abort_pre_ce", bus_u.ce, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_ce", bus_u.ce, 0);
        check("abort_we", bus_u.we, 0);
        check("abort_pc", dut.pc_q, 0);
        check("abort_r2", dut.r_q[2], 0);
        @(posedge ck);
        @(negedge ck);
        rst = 1'b0;
        rdy = 1'b1;
        @(negedge ck);
        check("abort_refetch_ce", bus_u.ce, 1);
        check("abort_refetch_addr", bus_u.address, 0);
        run_halt("abort_halt");
        check("abort_r1", dut.r_q[1], 16'h0009);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
